// File: rtl/game_pkg.sv
// Shared game types: sequencer state encoding and button prompt codes used by
// the sequencer, the button checker and the display decoder.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        SHOW,
        WAIT,
        RESOLVE,
        RELEASE,
        OVER
    } state_t;

    localparam logic [2:0] CODE_A     = 3'd1;
    localparam logic [2:0] CODE_B     = 3'd2;
    localparam logic [2:0] CODE_SEL   = 3'd3;
    localparam logic [2:0] CODE_UP    = 3'd4;
    localparam logic [2:0] CODE_DOWN  = 3'd5;
    localparam logic [2:0] CODE_LEFT  = 3'd6;
    localparam logic [2:0] CODE_RIGHT = 3'd7;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4 (maximal length)
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/prompt_lfsr.sv
// Prompt LFSR: loads the seed on reset or restart, otherwise advances when step is high.
module prompt_lfsr
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    input  logic       load,
    input  logic       step,
    output logic [7:0] state
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            state <= seed;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/prompt_sequencer.sv
// Game-round controller: draws a prompt, shows it, arms the button checker and scores it.
// Optional macro PROMPT_TIMEOUT_EN ends the game when the checker does not answer in time.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// GEN     | draw prompt from LFSR, redraw while code is 0
// SHOW    | prompt displayed for SHOW_CYCLES
// WAIT    | checker armed, collecting correct/done
// RESOLVE | score the round
// RELEASE | wait for checker to drop done before next round
// OVER    | game lost, score held until start
module prompt_sequencer
    import game_pkg::*;
#(
    parameter logic [7:0]  LFSR_SEED      = 8'hA5,
    parameter int unsigned SHOW_CYCLES    = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int          SCORE_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               chk_done,
    input  logic               chk_correct,
    output logic               chk_en,
    output logic [2:0]         chk_val,
    output logic               prompt_valid,
    output logic [2:0]         prompt_code,
    output logic [SCORE_W-1:0] score,
    output logic               busy,
    output logic               game_over
);

    localparam logic [31:0] SHOW_LOAD = 32'(SHOW_CYCLES - 1);
    localparam logic [31:0] TMO_LOAD  = 32'(TIMEOUT_CYCLES - 1);

    state_t             state, state_nx;
    logic [31:0]        cnt, cnt_nx;
    logic [2:0]         code, code_nx;
    logic               hit, hit_nx;
    logic [SCORE_W-1:0] score_nx;
    logic [7:0]         lfsr;
    logic               lfsr_load, lfsr_step;
    logic               lfsr_unused;

    logic               chk_en_nx, prompt_valid_nx, busy_nx, game_over_nx;
    logic [2:0]         chk_val_nx, prompt_code_nx;

    assign lfsr_step   = (state != IDLE) && (state != OVER);
    assign lfsr_unused = ^lfsr[7:3];

    prompt_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (LFSR_SEED),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .state (lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            code         <= '0;
            hit          <= 1'b0;
            score        <= '0;
            chk_en       <= 1'b0;
            chk_val      <= '0;
            prompt_valid <= 1'b0;
            prompt_code  <= '0;
            busy         <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            code         <= code_nx;
            hit          <= hit_nx;
            score        <= score_nx;
            chk_en       <= chk_en_nx;
            chk_val      <= chk_val_nx;
            prompt_valid <= prompt_valid_nx;
            prompt_code  <= prompt_code_nx;
            busy         <= busy_nx;
            game_over    <= game_over_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        code_nx   = code;
        hit_nx    = hit;
        score_nx  = score;
        lfsr_load = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = GEN;
                    score_nx = '0;
                end
            end
            GEN: begin
                if (lfsr[2:0] != 3'd0) begin
                    code_nx  = lfsr[2:0];
                    cnt_nx   = SHOW_LOAD;
                    state_nx = SHOW;
                end
            end
            SHOW: begin
                if (cnt == '0) begin
                    cnt_nx   = TMO_LOAD;
                    state_nx = WAIT;
                end else begin
                    cnt_nx = cnt - 32'd1;
                end
            end
            WAIT: begin
                if (chk_correct) begin
                    hit_nx = 1'b1;
                end
                if (chk_done) begin
                    state_nx = RESOLVE;
`ifdef PROMPT_TIMEOUT_EN
                end else if (cnt == '0) begin
                    // a late correct pulse does not survive into the next game
                    hit_nx   = 1'b0;
                    state_nx = OVER;
                end else begin
                    cnt_nx = cnt - 32'd1;
`endif
                end
            end
            RESOLVE: begin
                hit_nx = 1'b0;
                if (hit) begin
                    score_nx = (&score) ? score : score + SCORE_W'(1);
                    state_nx = RELEASE;
                end else begin
                    state_nx = OVER;
                end
            end
            RELEASE: begin
                if (!chk_done) begin
                    state_nx = GEN;
                end
            end
            OVER: begin
                if (start) begin
                    state_nx  = GEN;
                    score_nx  = '0;
                    lfsr_load = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // outputs decoded from the next state so the registered values line up with the state
    always_comb begin
        chk_en_nx       = (state_nx == WAIT);
        chk_val_nx      = (state_nx == WAIT) ? code_nx : 3'd0;
        prompt_valid_nx = (state_nx == SHOW) || (state_nx == WAIT);
        prompt_code_nx  = prompt_valid_nx ? code_nx : 3'd0;
        busy_nx         = (state_nx != IDLE) && (state_nx != OVER);
        game_over_nx    = (state_nx == OVER);
    end

endmodule

// File: tb/tb_prompt_sequencer.sv
// Self-checking bench for prompt_sequencer: an LFSR/score model predicts each round's
// prompt code and checker-arm cycle into a scoreboard, compared when chk_en rises.
module tb_prompt_sequencer;
    import game_pkg::*;

    localparam int         SHOW = 3;
    localparam int         TMO  = 10;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       rst, start, chk_done, chk_correct;
    logic       chk_en, prompt_valid, busy, game_over;
    logic [2:0] chk_val, prompt_code;
    logic [7:0] score;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [2:0] code;
        int         at;
    } exp_t;
    exp_t sb[$];

    logic [7:0] m_lfsr;
    int         m_g;
    logic [7:0] m_score;

    prompt_sequencer #(
        .LFSR_SEED      (SEED),
        .SHOW_CYCLES    (SHOW),
        .TIMEOUT_CYCLES (TMO),
        .SCORE_W        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .chk_done     (chk_done),
        .chk_correct  (chk_correct),
        .chk_en       (chk_en),
        .chk_val      (chk_val),
        .prompt_valid (prompt_valid),
        .prompt_code  (prompt_code),
        .score        (score),
        .busy         (busy),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] m_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] m_adv(input logic [7:0] s, input int n);
        logic [7:0] r;
        r = s;
        for (int i = 0; i < n; i++) r = m_step(r);
        return r;
    endfunction

    // GEN entered at posedge m_g with LFSR m_lfsr: predict the code and the WAIT entry posedge
    task automatic predict();
        logic [7:0] l;
        int         z;
        exp_t       e;
        l = m_lfsr;
        z = 0;
        while (l[2:0] == 3'd0 && z < 300) begin
            l = m_step(l);
            z++;
        end
        e.code = l[2:0];
        e.at   = m_g + z + 1 + SHOW;
        sb.push_back(e);
    endtask

    task automatic do_start();
        chk_done    = 1'b0;
        chk_correct = 1'b0;
        sb.delete();
        start = 1'b1;
        m_g   = cyc + 1;
        @(negedge clk);
        start   = 1'b0;
        m_lfsr  = SEED;
        m_score = 8'd0;
        predict();
        n_cmp++;
        if ({busy, game_over, score} !== {1'b1, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL start_entry: busy/game_over/score=%b/%b/%0d required 1/0/0", busy, game_over, score);
        end
    endtask

    task automatic wait_round();
        exp_t e;
        int   k;
        k = 0;
        while (chk_en !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (chk_en !== 1'b1) begin
            n_bad++;
            $display("FAIL chk_en_rise: chk_en=%b after %0d cycles, required 1", chk_en, k);
            return;
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: chk_en rose at cycle %0d with no prediction queued", cyc);
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if (cyc !== e.at) begin
            n_bad++;
            $display("FAIL arm_cycle: chk_en rose at cycle %0d, required %0d", cyc, e.at);
        end
        n_cmp++;
        if (chk_val !== e.code) begin
            n_bad++;
            $display("FAIL chk_val: got %0d required %0d", chk_val, e.code);
        end
        n_cmp++;
        if ({prompt_valid, prompt_code} !== {1'b1, e.code}) begin
            n_bad++;
            $display("FAIL prompt: valid/code=%b/%0d required 1/%0d", prompt_valid, prompt_code, e.code);
        end
    endtask

    // entered at a negedge inside WAIT; leaves at the negedge where done was dropped
    task automatic answer(input bit correct, input int extra);
        repeat (extra) @(negedge clk);
        chk_correct = correct;
        @(negedge clk);
        chk_correct = 1'b0;
        chk_done    = 1'b1;
        repeat (2) @(negedge clk);
        if (correct) m_score = (m_score == 8'hFF) ? 8'hFF : m_score + 8'd1;
        n_cmp++;
        if (score !== m_score) begin
            n_bad++;
            $display("FAIL score: got %0d required %0d", score, m_score);
        end
        n_cmp++;
        if ({busy, game_over, chk_en} !== (correct ? 3'b100 : 3'b010)) begin
            n_bad++;
            $display("FAIL after_resolve: busy/game_over/chk_en=%b required %b",
                     {busy, game_over, chk_en}, correct ? 3'b100 : 3'b010);
        end
        @(negedge clk);
        chk_done = 1'b0;
        if (correct) begin
            m_lfsr = m_adv(m_lfsr, cyc + 1 - m_g);
            m_g    = cyc + 1;
            predict();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; chk_done = 1'b0; chk_correct = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({chk_en, chk_val, prompt_valid, prompt_code, score, busy, game_over} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {chk_en, chk_val, prompt_valid, prompt_code, score, busy, game_over});
        end
        rst = 1'b0;
        chk_done = 1'b1; chk_correct = 1'b1;
        repeat (2) @(negedge clk);
        chk_done = 1'b0; chk_correct = 1'b0;
        n_cmp++;
        if ({chk_en, busy, game_over, score} !== '0) begin
            n_bad++;
            $display("FAIL idle_hold: chk_en/busy/game_over/score=%h required 0", {chk_en, busy, game_over, score});
        end
    endtask

    task automatic test_correct_rounds();
        do_start();
        wait_round();
        answer(1'b1, 0);
        wait_round();
        answer(1'b1, 1);
    endtask

    task automatic test_wrong_answer();
        wait_round();
        answer(1'b0, 0);
        chk_correct = 1'b1;
        @(negedge clk);
        chk_correct = 1'b0;
        chk_done    = 1'b1;
        repeat (3) @(negedge clk);
        chk_done = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({game_over, busy, chk_en, score} !== {1'b1, 1'b0, 1'b0, m_score}) begin
            n_bad++;
            $display("FAIL over_hold: game_over/busy/chk_en=%b score=%0d required 100 score=%0d",
                     {game_over, busy, chk_en}, score, m_score);
        end
    endtask

    task automatic test_start_busy_restart();
        do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_round();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        answer(1'b1, 0);
        wait_round();
        answer(1'b0, 2);
    endtask

    task automatic test_saturation();
        do_start();
        repeat (256) begin
            wait_round();
            answer(1'b1, 0);
        end
        n_cmp++;
        if (score !== 8'hFF) begin
            n_bad++;
            $display("FAIL saturate: score=%h required ff", score);
        end
        wait_round();
        answer(1'b0, 0);
    endtask

`ifdef PROMPT_TIMEOUT_EN
    task automatic test_timeout();
        do_start();
        wait_round();
        repeat (9) @(negedge clk);
        n_cmp++;
        if ({game_over, chk_en} !== 2'b01) begin
            n_bad++;
            $display("FAIL timeout_early: game_over/chk_en=%b required 01", {game_over, chk_en});
        end
        @(negedge clk);
        n_cmp++;
        if ({game_over, chk_en, busy, score} !== {3'b100, 8'd0}) begin
            n_bad++;
            $display("FAIL timeout_over: game_over/chk_en/busy=%b score=%0d required 100 score=0",
                     {game_over, chk_en, busy}, score);
        end
        do_start();
        wait_round();
        answer(1'b1, 8);
        wait_round();
        answer(1'b0, 0);
    endtask
`endif

    task automatic test_reset_in_wait();
        do_start();
        wait_round();
        rst = 1'b1;
        chk_correct = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({chk_en, chk_val, prompt_valid, prompt_code, score, busy, game_over} !== '0) begin
            n_bad++;
            $display("FAIL reset_in_wait: got %h required 0",
                     {chk_en, chk_val, prompt_valid, prompt_code, score, busy, game_over});
        end
        rst = 1'b0;
        chk_correct = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, game_over, chk_en} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_after_rst: busy/game_over/chk_en=%b required 000", {busy, game_over, chk_en});
        end
        do_start();
        wait_round();
        answer(1'b1, 0);
        wait_round();
        answer(1'b0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; chk_done = 1'b0; chk_correct = 1'b0;
        @(negedge clk);
        test_reset();
        test_correct_rounds();
        test_wrong_answer();
        test_start_busy_restart();
        test_saturation();
`ifdef PROMPT_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
